// File: rtl/baser_tc_pkg.sv
// Shared definitions for the 257b transcoded BASE-R lock checker:
// header constants, lock-state encoding and block classification.
package baser_tc_pkg;

    localparam logic        HDR_DATA   = 1'b1;
    localparam int unsigned MAX_BLOCKS = 8;

    typedef enum logic {
        HUNT,
        LOCKED
    } lock_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] pop;
    } blk_class_t;

    // pop counts control sub-blocks (mask bit 0) among the first n_blocks
    function automatic blk_class_t classify(
        input logic                  hdr,
        input logic [MAX_BLOCKS-1:0] mask,
        input int unsigned           n_blocks
    );
        blk_class_t r;
        r.pop = 4'd0;
        for (int unsigned i = 0; i < MAX_BLOCKS; i++) begin
            if (i < n_blocks && !mask[i]) begin
                r.pop = r.pop + 4'd1;
            end
        end
        r.valid = (hdr == HDR_DATA) || (r.pop != 4'd0);
        return r;
    endfunction

endpackage

// File: rtl/baser_sat_counter.sv
// Saturating up-counter with synchronous clear; an add that would
// overflow clamps to all-ones instead of wrapping.
module baser_sat_counter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned INC_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic [INC_WIDTH-1:0] i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH:0]   sum;

    assign sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(i_inc);

    always_comb begin
        cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        if (i_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/baser_257b_lock_checker.sv
// Block-lock monitor and statistics for 257b transcoded BASE-R blocks.
// Lock FSM present only when BASER_257B_LOCK_CHECKER_LOCK_EN is defined.
module baser_257b_lock_checker
    import baser_tc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned N_BLOCKS   = 4,
    parameter int unsigned TC_WIDTH   = N_BLOCKS * DATA_WIDTH + 1,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [TC_WIDTH-1:0]  i_tx_coded,
    input  logic                 i_clear,
    output logic                 o_lock,
    output logic [CNT_WIDTH-1:0] o_block_count,
    output logic [CNT_WIDTH-1:0] o_data_count,
    output logic [CNT_WIDTH-1:0] o_ctrl_count,
    output logic [CNT_WIDTH-1:0] o_ctrl_sub_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic                 o_err
);

    localparam int unsigned INC_W = $clog2(N_BLOCKS + 1);

    if (N_BLOCKS < 1 || N_BLOCKS > MAX_BLOCKS || LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_bad_cfg
        $error("baser_257b_lock_checker: unsupported parameters");
    end

    logic [MAX_BLOCKS-1:0] mask;
    blk_class_t            cls;
    logic                  hdr;
    logic                  accept;
    logic                  bad_blk;
    logic                  err_q;
    logic                  unused_payload;

    assign mask           = MAX_BLOCKS'(i_tx_coded[N_BLOCKS:1]);
    assign hdr            = i_tx_coded[0];
    assign cls            = classify(hdr, mask, N_BLOCKS);
    assign bad_blk        = i_valid && !cls.valid;
    assign unused_payload = ^i_tx_coded[TC_WIDTH-1:N_BLOCKS+1];

`ifdef BASER_257B_LOCK_CHECKER_LOCK_EN
    localparam int unsigned RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

    lock_state_e      state_q, state_d;
    logic [RUN_W-1:0] good_q, good_d;
    logic [RUN_W-1:0] bad_q, bad_d;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (i_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (!cls.valid) begin
                        good_d = '0;
                    end else if (good_q == RUN_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (cls.valid) begin
                        bad_d = '0;
                    end else if (bad_q == RUN_W'(UNLOCK_CNT - 1)) begin
                        state_d = HUNT;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + RUN_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= HUNT;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // the block that completes lock is judged against the old state
    assign accept = i_valid && (state_q == LOCKED);
    assign o_lock = (state_q == LOCKED);
`else
    assign accept = i_valid;
    assign o_lock = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bad_blk;
        end
    end

    assign o_err = err_q;

    logic             acc_data;
    logic             acc_ctrl;
    logic [INC_W-1:0] sub_inc;

    assign acc_data = accept && cls.valid && hdr;
    assign acc_ctrl = accept && cls.valid && !hdr;
    assign sub_inc  = acc_ctrl ? cls.pop[INC_W-1:0] : '0;

    baser_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_blk_cnt (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_inc(INC_W'(accept)), .o_count(o_block_count)
    );

    baser_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_data_cnt (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_inc(INC_W'(acc_data)), .o_count(o_data_count)
    );

    baser_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_ctrl_cnt (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_inc(INC_W'(acc_ctrl)), .o_count(o_ctrl_count)
    );

    baser_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_sub_cnt (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_inc(sub_inc), .o_count(o_ctrl_sub_count)
    );

    baser_sat_counter #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_err_cnt (
        .clk(clk), .i_rst(i_rst), .i_clear(i_clear),
        .i_inc(INC_W'(bad_blk)), .o_count(o_err_count)
    );

endmodule

// File: tb/tb_baser_257b_lock_checker.sv
// Randomised self-checking bench: two checker instances (32b and 4b
// counters) driven in parallel and compared against a behavioural model.
module tb_baser_257b_lock_checker;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int TCW = N * DW + 1;
    localparam int CWA = 32;
    localparam int CWB = 4;

`ifdef BASER_257B_LOCK_CHECKER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic           clr;
    logic [TCW-1:0] tx;

    logic           lock_a, err_a, lock_b, err_b;
    logic [CWA-1:0] blk_a, data_a, ctrl_a, sub_a, errc_a;
    logic [CWB-1:0] blk_b, data_b, ctrl_b, sub_b, errc_b;

    always #5 clk = ~clk;

    baser_257b_lock_checker #(.N_BLOCKS(N), .CNT_WIDTH(CWA)) u_dut_a (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_tx_coded(tx), .i_clear(clr),
        .o_lock(lock_a), .o_block_count(blk_a), .o_data_count(data_a),
        .o_ctrl_count(ctrl_a), .o_ctrl_sub_count(sub_a),
        .o_err_count(errc_a), .o_err(err_a)
    );

    baser_257b_lock_checker #(.N_BLOCKS(N), .CNT_WIDTH(CWB)) u_dut_b (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_tx_coded(tx), .i_clear(clr),
        .o_lock(lock_b), .o_block_count(blk_b), .o_data_count(data_b),
        .o_ctrl_count(ctrl_b), .o_ctrl_sub_count(sub_b),
        .o_err_count(errc_b), .o_err(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // model state: unbounded counts, clamped to each width on compare
    bit      m_lock;
    bit      m_err;
    int      m_good, m_bad;
    longint  m_blk, m_data, m_ctrl, m_sub, m_errc;

    function automatic logic [63:0] sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? 64'(lim) : 64'(v);
    endfunction

    task automatic zero_counts();
        m_blk = 0; m_data = 0; m_ctrl = 0; m_sub = 0; m_errc = 0;
    endtask

    task automatic model(input bit r, input bit v, input bit h, input logic [3:0] m, input bit c);
        int  zeros;
        bit  ok;
        bit  acc;
        if (r) begin
            zero_counts();
            m_err  = 0;
            m_lock = !LOCK_EN;
            m_good = 0;
            m_bad  = 0;
            return;
        end
        m_err = 0;
        if (!v) begin
            if (c) zero_counts();
            return;
        end
        zeros = $countones(~m);
        ok    = h || (zeros > 0);
        acc   = m_lock;
        if (LOCK_EN) begin
            if (!m_lock) begin
                m_good = ok ? m_good + 1 : 0;
                if (m_good == 64) begin
                    m_lock = 1;
                    m_good = 0;
                end
            end else begin
                m_bad = ok ? 0 : m_bad + 1;
                if (m_bad == 16) begin
                    m_lock = 0;
                    m_bad  = 0;
                    m_good = 0;
                end
            end
        end
        m_err = !ok;
        if (c) begin
            zero_counts();
        end else begin
            if (acc) m_blk++;
            if (acc && ok && h) m_data++;
            if (acc && ok && !h) begin
                m_ctrl++;
                m_sub += zeros;
            end
            if (!ok) m_errc++;
        end
    endtask

    task automatic check_all();
        check("lock_a", 64'(lock_a), 64'(m_lock));
        check("err_a", 64'(err_a), 64'(m_err));
        check("blk_a", 64'(blk_a), sat(m_blk, CWA));
        check("data_a", 64'(data_a), sat(m_data, CWA));
        check("ctrl_a", 64'(ctrl_a), sat(m_ctrl, CWA));
        check("sub_a", 64'(sub_a), sat(m_sub, CWA));
        check("errc_a", 64'(errc_a), sat(m_errc, CWA));
        check("lock_b", 64'(lock_b), 64'(m_lock));
        check("err_b", 64'(err_b), 64'(m_err));
        check("blk_b", 64'(blk_b), sat(m_blk, CWB));
        check("data_b", 64'(data_b), sat(m_data, CWB));
        check("ctrl_b", 64'(ctrl_b), sat(m_ctrl, CWB));
        check("sub_b", 64'(sub_b), sat(m_sub, CWB));
        check("errc_b", 64'(errc_b), sat(m_errc, CWB));
    endtask

    task automatic step(input bit r, input bit v, input bit h, input logic [3:0] m, input bit c);
        for (int i = 0; i < 8; i++) tx[i*32 +: 32] = $urandom;
        tx[TCW-1] = 1'($urandom);
        tx[N:1]   = m;
        tx[0]     = h;
        rst   = r;
        valid = v;
        clr   = c;
        @(posedge clk);
        model(r, v, h, m, c);
        #1;
        check_all();
    endtask

    // kind: 0 all-data, 1 valid control, 2 invalid, 3 mask 1010
    task automatic run(input int n, input int kind);
        logic [3:0] m;
        for (int i = 0; i < n; i++) begin
            m = 4'($urandom);
            unique case (kind)
                0: step(0, 1, 1, m, 0);
                1: begin
                    while (m == 4'hF) m = 4'($urandom);
                    step(0, 1, 0, m, 0);
                end
                2: step(0, 1, 0, 4'hF, 0);
                default: step(0, 1, 0, 4'b1010, 0);
            endcase
        end
    endtask

    initial begin
        int rate;
        logic [3:0] m;
        bit h;
        rst = 1; valid = 0; clr = 0; tx = '0;
        m_lock = 0; m_err = 0; m_good = 0; m_bad = 0;
        zero_counts();

        for (int i = 0; i < 20; i++) step(1, 0, 0, 4'h0, 0);
        run(64, 0);
        run(10, 0);
        run(3, 3);
        run(16, 2);
        run(64, 1);
        run(15, 2);
        run(1, 0);
        run(15, 2);
        run(1, 1);
        run(16, 2);
        run(63, 0);
        run(1, 2);
        run(63, 1);
        run(1, 0);
        run(20, 0);
        step(0, 1, 1, 4'h3, 1);
        run(5, 1);
        step(0, 1, 0, 4'hF, 1);
        step(0, 1, 0, 4'hF, 0);
        step(1, 1, 0, 4'hF, 1);
        run(63, 0);
        run(1, 1);
        run(4, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rate = $urandom_range(2, 60);
            m = 4'($urandom);
            h = 1'($urandom);
            if ($urandom_range(0, rate - 1) == 0) begin
                h = 0;
                m = 4'hF;
            end else if (!h && m == 4'hF) begin
                m = 4'h0;
            end
            step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
                 h, m, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
